// File: rtl/riscv_nn_irq_arbiter_if.sv
// Request/ack bundle between the interrupt source stage and the core interrupt controller.
// The slave side is the arbiter; the master side drives lines, CSR writes and acks.
interface riscv_nn_irq_arbiter_if #(
  parameter int NUM_IRQ = 32
);
  logic [NUM_IRQ-1:0] irq_lines_i;
  logic [NUM_IRQ-1:0] sw_set_i;
  logic               mask_we_i;
  logic [NUM_IRQ-1:0] mask_i;
  logic               sec_we_i;
  logic [NUM_IRQ-1:0] sec_i;
  logic               irq_o;
  logic [4:0]         irq_id_o;
  logic               irq_sec_o;
  logic               irq_ack_i;
  logic [4:0]         irq_ack_id_i;
  logic [NUM_IRQ-1:0] pending_o;

  modport slave (
    input  irq_lines_i, sw_set_i, mask_we_i, mask_i, sec_we_i, sec_i,
    input  irq_ack_i, irq_ack_id_i,
    output irq_o, irq_id_o, irq_sec_o, pending_o
  );

  modport master (
    output irq_lines_i, sw_set_i, mask_we_i, mask_i, sec_we_i, sec_i,
    output irq_ack_i, irq_ack_id_i,
    input  irq_o, irq_id_o, irq_sec_o, pending_o
  );
endinterface

// File: rtl/riscv_nn_irq_arbiter.sv
// Interrupt source stage: edge/level pending capture, masking, highest-index arbitration
// and a held request to the core until it acks or the request loses its enable.
module riscv_nn_irq_arbiter #(
  parameter int                 NUM_IRQ   = 32,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1
) (
  input  logic                    clk,
  input  logic                    rst,
  riscv_nn_irq_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_sec;
  logic               r_irq;
  logic [4:0]         r_id;
  logic               r_sec_out;

  state_t             w_state_nxt;
  logic               w_irq_nxt;
  logic [4:0]         w_id_nxt;
  logic               w_sec_nxt;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pend_nxt;
  logic [NUM_IRQ-1:0] w_en;
  logic [31:0]        w_en_pad;
  logic [31:0]        w_sec_pad;
  logic [4:0]         w_winner;

  assign w_rise    = bus.irq_lines_i & ~r_prev;
  assign w_en      = r_pending & r_mask;
  // Zero-extend to 32 so any 5-bit id can index safely when NUM_IRQ < 32.
  assign w_en_pad  = 32'(w_en);
  assign w_sec_pad = 32'(r_sec);

  // Ack ids at or above NUM_IRQ match no bit and so clear nothing.
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i] = bus.irq_ack_i && (bus.irq_ack_id_i == 5'(i));
    end
  end

  // Set terms are OR-ed after the clear, so a same-cycle set beats the ack.
  assign w_pend_nxt = (EDGE_MASK & ((r_pending & ~w_clr) | w_rise | bus.sw_set_i))
                    | (~EDGE_MASK & bus.irq_lines_i);

  always_comb begin
    w_winner = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_en[i]) w_winner = 5'(i);
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned
    // (which would infer a latch).
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_id_nxt    = r_id;
    w_sec_nxt   = r_sec_out;
    case (r_state)
      S_IDLE: begin
        if (|w_en) begin
          w_state_nxt = S_REQ;
          w_irq_nxt   = 1'b1;
          w_id_nxt    = w_winner;
          w_sec_nxt   = w_sec_pad[w_winner];
        end
      end
      S_REQ: begin
        if (bus.irq_ack_i) begin
          w_state_nxt = S_GAP;
          w_irq_nxt   = 1'b0;
        end else if (!w_en_pad[r_id]) begin
          w_state_nxt = S_IDLE;
          w_irq_nxt   = 1'b0;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
        w_sec_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_irq_nxt   = 1'b0;
      end
    endcase
  end

  // NOTE: every register here is small control state, so all of it is reset; a reset
  // mid-request deliberately drops pending events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_prev    <= '0;
      r_mask    <= '0;
      r_sec     <= '0;
      r_irq     <= 1'b0;
      r_id      <= '0;
      r_sec_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_pending <= w_pend_nxt;
      r_prev    <= bus.irq_lines_i;
      r_irq     <= w_irq_nxt;
      r_id      <= w_id_nxt;
      r_sec_out <= w_sec_nxt;
      if (bus.mask_we_i) r_mask <= bus.mask_i;
      if (bus.sec_we_i)  r_sec  <= bus.sec_i;
    end
  end

  assign bus.irq_o     = r_irq;
  assign bus.irq_id_o  = r_id;
  assign bus.irq_sec_o = r_sec_out;
  assign bus.pending_o = r_pending;

endmodule

// File: tb/tb_riscv_nn_irq_arbiter.sv
// Scoreboard bench: a behavioural model pushes the expected outputs after each clock edge,
// a monitor pops and compares them on the falling edge.
module tb_riscv_nn_irq_arbiter;

  localparam logic [31:0] EDGE = 32'hFFFF_FFFE;  // line 0 is level, all others edge

  typedef struct packed {
    logic        irq;
    logic [4:0]  id;
    logic        sec;
    logic [31:0] pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  riscv_nn_irq_arbiter_if #(.NUM_IRQ(32)) bus ();

  riscv_nn_irq_arbiter #(.NUM_IRQ(32), .EDGE_MASK(EDGE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain variables updated once per clock from the rules of the block.
  logic [31:0] m_pend, m_prev, m_mask, m_sec;
  bit          m_active, m_gap, m_sec_out;
  logic [4:0]  m_id;

  function automatic exp_t snapshot();
    exp_t e;
    e.irq  = m_active;
    e.id   = m_id;
    e.sec  = m_sec_out;
    e.pend = m_pend;
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend = '0; m_prev = '0; m_mask = '0; m_sec = '0;
        m_active = 1'b0; m_gap = 1'b0; m_sec_out = 1'b0; m_id = '0;
        exp_q.delete();
        exp_q.push_back(snapshot());
      end else begin
        logic [31:0] en, clr, rise, npend;
        logic [4:0]  win;
        bit          found;
        en    = m_pend & m_mask;
        clr   = bus.irq_ack_i ? (32'(1) << bus.irq_ack_id_i) : 32'h0;
        rise  = bus.irq_lines_i & ~m_prev;
        npend = (EDGE & ((m_pend & ~clr) | rise | bus.sw_set_i)) | (~EDGE & bus.irq_lines_i);
        win   = '0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
          if (!found && en[i]) begin
            win   = 5'(i);
            found = 1'b1;
          end
        end
        if (m_gap) begin
          m_gap     = 1'b0;
          m_sec_out = 1'b0;
        end else if (m_active) begin
          if (bus.irq_ack_i) begin
            m_active = 1'b0;
            m_gap    = 1'b1;
          end else if (!en[m_id]) begin
            m_active = 1'b0;
          end
        end else if (found) begin
          m_active  = 1'b1;
          m_id      = win;
          m_sec_out = m_sec[win];
        end
        m_pend = npend;
        m_prev = bus.irq_lines_i;
        if (bus.mask_we_i) m_mask = bus.mask_i;
        if (bus.sec_we_i)  m_sec  = bus.sec_i;
        exp_q.push_back(snapshot());
      end
    end
  end

  // Monitor: the DUT presents a full output set every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("irq_o",     32'(bus.irq_o),     32'(e.irq));
        check("irq_id_o",  32'(bus.irq_id_o),  32'(e.id));
        check("irq_sec_o", 32'(bus.irq_sec_o), 32'(e.sec));
        check("pending_o", bus.pending_o,      e.pend);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    for (int n = 0; n < 20 && !bus.irq_o; n++) step();
    check(name, 32'(bus.irq_o), 32'd1);
  endtask

  task automatic ack(input logic [4:0] id);
    bus.irq_ack_i    = 1'b1;
    bus.irq_ack_id_i = id;
    step();
    bus.irq_ack_i    = 1'b0;
  endtask

  task automatic pulse_line(input int idx);
    bus.irq_lines_i[idx] = 1'b1;
    step();
    bus.irq_lines_i[idx] = 1'b0;
  endtask

  task automatic write_mask(input logic [31:0] v);
    bus.mask_we_i = 1'b1;
    bus.mask_i    = v;
    step();
    bus.mask_we_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.irq_lines_i = '0; bus.sw_set_i = '0; bus.mask_we_i = 1'b0; bus.mask_i = '0;
    bus.sec_we_i = 1'b0; bus.sec_i = '0; bus.irq_ack_i = 1'b0; bus.irq_ack_id_i = '0;
    #1 rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();

    // Single edge on line 8
    write_mask(32'h0000_0100);
    pulse_line(8);
    wait_req("req_edge8");
    ack(5'd8);
    repeat (4) step();

    // Priority: 17 before 3
    write_mask(32'hFFFF_FFFF);
    bus.irq_lines_i[3]  = 1'b1;
    bus.irq_lines_i[17] = 1'b1;
    step();
    bus.irq_lines_i[3]  = 1'b0;
    bus.irq_lines_i[17] = 1'b0;
    wait_req("req_prio17");
    ack(5'd17);
    wait_req("req_prio3");
    ack(5'd3);
    repeat (3) step();

    // Set/clear collision on line 5
    pulse_line(5);
    wait_req("req_coll5");
    bus.irq_lines_i[5] = 1'b1;
    bus.irq_ack_i      = 1'b1;
    bus.irq_ack_id_i   = 5'd5;
    step();
    bus.irq_lines_i[5] = 1'b0;
    bus.irq_ack_i      = 1'b0;
    wait_req("req_coll5_again");
    ack(5'd5);
    repeat (3) step();

    // Withdraw on mask clear
    pulse_line(12);
    wait_req("req_wd12");
    write_mask(~(32'(1) << 12));
    repeat (4) step();

    // Level line 0, secure
    write_mask(32'h0000_0001);
    bus.sec_we_i = 1'b1;
    bus.sec_i    = 32'h0000_0001;
    step();
    bus.sec_we_i = 1'b0;
    bus.irq_lines_i[0] = 1'b1;
    wait_req("req_lvl0");
    ack(5'd0);
    wait_req("req_lvl0_again");
    bus.irq_lines_i[0] = 1'b0;
    repeat (4) step();

    // Reset in the middle of a request
    write_mask(32'hFFFF_FFFF);
    pulse_line(20);
    wait_req("req_rst20");
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();

    // Randomized traffic
    write_mask($urandom);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0)
        bus.irq_lines_i = bus.irq_lines_i ^ (32'(1) << 5'($urandom_range(0, 31)));
      bus.sw_set_i  = ($urandom_range(0, 7) == 0) ? (32'(1) << 5'($urandom_range(0, 31))) : 32'h0;
      bus.mask_we_i = ($urandom_range(0, 31) == 0);
      bus.mask_i    = $urandom;
      bus.sec_we_i  = ($urandom_range(0, 31) == 0);
      bus.sec_i     = $urandom;
      if (bus.irq_o && $urandom_range(0, 2) == 0) begin
        bus.irq_ack_i    = 1'b1;
        bus.irq_ack_id_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : bus.irq_id_o;
      end else begin
        bus.irq_ack_i    = ($urandom_range(0, 31) == 0);
        bus.irq_ack_id_i = 5'($urandom_range(0, 31));
      end
      step();
    end
    bus.irq_lines_i = '0; bus.sw_set_i = '0; bus.mask_we_i = 1'b0;
    bus.sec_we_i = 1'b0; bus.irq_ack_i = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
